// File: rtl/and_gate_bist_ctrl_if.sv
// Bus between the AND-gate BIST controller and the top level that owns the gate.
// The top level (master) requests runs and returns the gate output; the
// controller (slave) drives the gate inputs and reports status.
interface and_gate_bist_ctrl_if #(
    parameter int LOOPS_W = 8
);
    logic               start;
    logic               abort;
    logic [LOOPS_W-1:0] loops;
    logic               gate_y;
    logic               gate_a;
    logic               gate_b;
    logic               busy;
    logic               done;
    logic               pass;
    logic [7:0]         fail_count;
    logic [3:0]         fail_vec;

    modport master (
        output start, abort, loops, gate_y,
        input  gate_a, gate_b, busy, done, pass, fail_count, fail_vec
    );

    modport slave (
        input  start, abort, loops, gate_y,
        output gate_a, gate_b, busy, done, pass, fail_count, fail_vec
    );
endinterface

// File: rtl/and_gate_bist_ctrl.sv
// Built-in self-test sequencer for the top-level 2-input AND gate.
// Walks the four-entry truth table for a programmable number of passes,
// holding each vector SETTLE_CYCLES cycles before sampling gate_y on one
// extra cycle, and keeps a pass flag, a saturating mismatch count and a
// per-vector failure map. loops=0 keeps cycling until abort.
module and_gate_bist_ctrl #(
    parameter int SETTLE_CYCLES = 4,
    parameter int LOOPS_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    and_gate_bist_ctrl_if.slave  bus
);

    // A settle time of zero (or beyond the 8-bit counter) cannot be honoured,
    // so such a configuration is made to fail elaboration.
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        illegal_settle_cycles_parameter u_illegal_settle_cycles ();
    end

    localparam logic [7:0]         SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [LOOPS_W-1:0] LOOP_ONE    = LOOPS_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t             state_q,      state_d;
    logic [1:0]         idx_q,        idx_d;
    logic [7:0]         settle_q,     settle_d;
    logic [LOOPS_W-1:0] loop_q,       loop_d;
    logic [LOOPS_W-1:0] loops_q,      loops_d;
    logic               gate_a_q,     gate_a_d;
    logic               gate_b_q,     gate_b_d;
    logic               busy_q,       busy_d;
    logic               done_q,       done_d;
    logic               pass_q,       pass_d;
    logic [7:0]         fail_count_q, fail_count_d;
    logic [3:0]         fail_vec_q,   fail_vec_d;

    logic               expected_y;
    logic               mismatch;
    logic [7:0]         fail_count_inc;
    logic [LOOPS_W-1:0] loop_next;
    logic               last_loop;

    // Expected response comes from the vector index, not from the gate pins,
    // so a fault on the gate input path cannot hide itself.
    assign expected_y     = idx_q[1] & idx_q[0];
    assign mismatch       = bus.gate_y != expected_y;
    assign fail_count_inc = (fail_count_q == 8'hFF) ? fail_count_q : fail_count_q + 8'd1;
    assign loop_next      = loop_q + LOOP_ONE;
    assign last_loop      = (loops_q != '0) && (loop_next == loops_q);

    // Next-state and next-output logic; every register holds unless a
    // transition below says otherwise, and done is a single-cycle strobe.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        settle_d     = settle_q;
        loop_d       = loop_q;
        loops_d      = loops_q;
        gate_a_d     = gate_a_q;
        gate_b_d     = gate_b_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        fail_count_d = fail_count_q;
        fail_vec_d   = fail_vec_q;

        case (state_q)
            IDLE: begin
                gate_a_d = 1'b0;
                gate_b_d = 1'b0;
                busy_d   = 1'b0;
                if (bus.start && !bus.abort) begin
                    loops_d      = bus.loops;
                    fail_count_d = 8'd0;
                    fail_vec_d   = 4'd0;
                    pass_d       = 1'b0;
                    loop_d       = '0;
                    settle_d     = 8'd0;
                    idx_d        = 2'd0;
                    busy_d       = 1'b1;
                    state_d      = SETTLE;
                end
            end

            SETTLE: begin
                if (bus.abort) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    gate_a_d = 1'b0;
                    gate_b_d = 1'b0;
                    pass_d   = 1'b0;
                    settle_d = 8'd0;
                end else if (settle_q == SETTLE_LAST) begin
                    settle_d = 8'd0;
                    state_d  = SAMPLE;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end

            SAMPLE: begin
                if (bus.abort) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    gate_a_d = 1'b0;
                    gate_b_d = 1'b0;
                    pass_d   = 1'b0;
                end else begin
                    if (mismatch) begin
                        fail_count_d      = fail_count_inc;
                        fail_vec_d[idx_q] = 1'b1;
                    end
                    if (idx_q != 2'd3) begin
                        idx_d    = idx_q + 2'd1;
                        gate_a_d = idx_d[1];
                        gate_b_d = idx_d[0];
                        state_d  = SETTLE;
                    end else if (last_loop) begin
                        state_d  = FINISH;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        gate_a_d = 1'b0;
                        gate_b_d = 1'b0;
                        pass_d   = (fail_count_d == 8'd0);
                    end else begin
                        loop_d   = loop_next;
                        idx_d    = 2'd0;
                        gate_a_d = 1'b0;
                        gate_b_d = 1'b0;
                        state_d  = SETTLE;
                    end
                end
            end

            FINISH: begin
                state_d  = IDLE;
                gate_a_d = 1'b0;
                gate_b_d = 1'b0;
                busy_d   = 1'b0;
                if (bus.abort) begin
                    pass_d = 1'b0;
                end
            end

            default: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                gate_a_d = 1'b0;
                gate_b_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= 2'd0;
            settle_q     <= 8'd0;
            loop_q       <= '0;
            loops_q      <= '0;
            gate_a_q     <= 1'b0;
            gate_b_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_count_q <= 8'd0;
            fail_vec_q   <= 4'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            settle_q     <= settle_d;
            loop_q       <= loop_d;
            loops_q      <= loops_d;
            gate_a_q     <= gate_a_d;
            gate_b_q     <= gate_b_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_count_q <= fail_count_d;
            fail_vec_q   <= fail_vec_d;
        end
    end

    assign bus.gate_a     = gate_a_q;
    assign bus.gate_b     = gate_b_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.fail_count = fail_count_q;
    assign bus.fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_and_gate_bist_ctrl.sv
// Testbench for and_gate_bist_ctrl: a faulty-gate model driven by a per-vector
// flip mask, a run-level reference model, and a done-triggered scoreboard.
module tb_and_gate_bist_ctrl;

    localparam int SETTLE_CYCLES = 4;
    localparam int LOOPS_W       = 8;
    localparam int VEC_CYCLES    = SETTLE_CYCLES + 1;

    typedef struct {
        int fail_count;
        int fail_vec;
        int pass;
        int cycles;
    } result_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] fault_mask;

    int assertions = 0;
    int failures   = 0;

    result_t sb[$];

    int      mon_cycles;
    logic    mon_prev_busy;
    logic    mon_prev_done;
    result_t mon_exp;

    and_gate_bist_ctrl_if #(.LOOPS_W(LOOPS_W)) bif ();

    and_gate_bist_ctrl #(
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .LOOPS_W(LOOPS_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bif)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Gate under test: a true AND with selected truth-table rows inverted.
    always_comb bif.gate_y = (bif.gate_a & bif.gate_b) ^ fault_mask[{bif.gate_a, bif.gate_b}];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Outcome of a complete run: every faulty row fails once per pass.
    function automatic result_t modelRun(input logic [3:0] mask, input int nloops);
        result_t r;
        int hits = 0;
        for (int v = 0; v < 4; v++) if (mask[v]) hits++;
        r.fail_count = (hits * nloops > 255) ? 255 : hits * nloops;
        r.fail_vec   = int'(mask);
        r.pass       = (hits == 0) ? 1 : 0;
        r.cycles     = nloops * 4 * VEC_CYCLES;
        return r;
    endfunction

    // Outcome of a run aborted k edges after the start edge: samples land on
    // every VEC_CYCLES-th edge, and one landing on the abort edge is lost.
    function automatic result_t modelAbort(input logic [3:0] mask, input int k);
        result_t r;
        int samples = (k - 1) / VEC_CYCLES;
        r.fail_count = 0;
        r.fail_vec   = 0;
        r.pass       = 0;
        r.cycles     = 0;
        for (int j = 0; j < samples; j++) begin
            if (mask[j % 4]) begin
                if (r.fail_count < 255) r.fail_count++;
                r.fail_vec = r.fail_vec | (1 << (j % 4));
            end
        end
        return r;
    endfunction

    task automatic startRun(input logic [3:0] mask, input int nloops);
        fault_mask = mask;
        @(posedge clk);
        #1;
        bif.start = 1'b1;
        bif.loops = LOOPS_W'(nloops);
        @(posedge clk);
        #1;
        bif.start = 1'b0;
    endtask

    task automatic waitRunEnd(input int budget);
        int n = 0;
        while (bif.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("run_end_busy", bif.busy, 0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("sb_drained", sb.size(), 0);
    endtask

    // Full run expected to complete: queue the model result, then check the
    // sticky status once the block is idle again.
    task automatic applyStimulus(input logic [3:0] mask, input int nloops);
        result_t r = modelRun(mask, nloops);
        sb.push_back(r);
        startRun(mask, nloops);
        waitRunEnd(nloops * 4 * VEC_CYCLES + 50);
        checkOutput("pass_sticky", bif.pass, r.pass);
        checkOutput("fail_count_hold", bif.fail_count, r.fail_count);
        checkOutput("fail_vec_hold", bif.fail_vec, r.fail_vec);
    endtask

    // Run aborted on the k-th edge after start; status must freeze there.
    task automatic abortRun(input logic [3:0] mask, input int nloops, input int k);
        result_t r = modelAbort(mask, k);
        startRun(mask, nloops);
        repeat (k - 1) @(posedge clk);
        #1;
        bif.abort = 1'b1;
        @(posedge clk);
        #1;
        bif.abort = 1'b0;
        checkOutput("abort_busy", bif.busy, 0);
        checkOutput("abort_gates", {bif.gate_a, bif.gate_b}, 0);
        checkOutput("abort_pass", bif.pass, 0);
        checkOutput("abort_done", bif.done, 0);
        checkOutput("abort_fail_count", bif.fail_count, r.fail_count);
        checkOutput("abort_fail_vec", bif.fail_vec, r.fail_vec);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("abort_stays_idle", bif.busy, 0);
    endtask

    // Monitor: gate sequencing every cycle, and a scoreboard pop on each done.
    initial begin
        mon_cycles    = 0;
        mon_prev_busy = 1'b0;
        mon_prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                mon_cycles    = 0;
                mon_prev_busy = 1'b0;
                mon_prev_done = 1'b0;
                checkOutput("gate_reset", {bif.gate_a, bif.gate_b}, 0);
            end else begin
                if (bif.busy) begin
                    if (!mon_prev_busy) mon_cycles = 0;
                    mon_cycles++;
                    checkOutput("gate_seq", {bif.gate_a, bif.gate_b}, ((mon_cycles - 1) / VEC_CYCLES) % 4);
                end else begin
                    checkOutput("gate_idle", {bif.gate_a, bif.gate_b}, 0);
                end
                if (bif.done) begin
                    checkOutput("done_width", mon_prev_done, 0);
                    checkOutput("done_busy", bif.busy, 0);
                    if (sb.size() == 0) begin
                        checkOutput("done_spurious", bif.done, 0);
                    end else begin
                        mon_exp = sb.pop_front();
                        checkOutput("sb_fail_count", bif.fail_count, mon_exp.fail_count);
                        checkOutput("sb_fail_vec", bif.fail_vec, mon_exp.fail_vec);
                        checkOutput("sb_pass", bif.pass, mon_exp.pass);
                        checkOutput("sb_busy_cycles", mon_cycles, mon_exp.cycles);
                    end
                end
                mon_prev_busy = bif.busy;
                mon_prev_done = bif.done;
            end
        end
    end

    // Directed scenarios followed by randomized runs and aborts.
    initial begin
        result_t r;
        logic [3:0] m;
        int n;

        rst_n      = 1'b0;
        bif.start  = 1'b0;
        bif.abort  = 1'b0;
        bif.loops  = '0;
        fault_mask = 4'd0;
        #1;
        checkOutput("reset_busy", bif.busy, 0);
        checkOutput("reset_done", bif.done, 0);
        checkOutput("reset_pass", bif.pass, 0);
        checkOutput("reset_fail_count", bif.fail_count, 0);
        checkOutput("reset_fail_vec", bif.fail_vec, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // start and abort together in IDLE: abort wins
        @(posedge clk);
        #1;
        bif.start = 1'b1;
        bif.abort = 1'b1;
        @(posedge clk);
        #1;
        bif.start = 1'b0;
        bif.abort = 1'b0;
        checkOutput("start_abort_idle", bif.busy, 0);

        $display("[TB] good gate, one pass");
        applyStimulus(4'b0000, 1);

        $display("[TB] stuck-at-1, two passes");
        applyStimulus(4'b0111, 2);

        $display("[TB] stuck-at-0, three passes with ignored mid-run start");
        r = modelRun(4'b1000, 3);
        sb.push_back(r);
        startRun(4'b1000, 3);
        repeat (20) @(posedge clk);
        #1;
        bif.start = 1'b1;
        bif.loops = 8'd1;
        @(posedge clk);
        #1;
        bif.start = 1'b0;
        waitRunEnd(200);
        checkOutput("s0_pass", bif.pass, r.pass);
        checkOutput("s0_fail_count", bif.fail_count, r.fail_count);

        $display("[TB] abort on edge 7, then clean rerun");
        abortRun(4'b0000, 1, 7);
        applyStimulus(4'b0000, 1);

        $display("[TB] endless run saturates the fail count");
        startRun(4'b0111, 0);
        repeat (2000) @(posedge clk);
        #1;
        checkOutput("sat_fail_count", bif.fail_count, 255);
        checkOutput("sat_busy", bif.busy, 1);
        bif.abort = 1'b1;
        @(posedge clk);
        #1;
        bif.abort = 1'b0;
        checkOutput("sat_abort_busy", bif.busy, 0);
        checkOutput("sat_abort_fail_count", bif.fail_count, 255);
        checkOutput("sat_abort_fail_vec", bif.fail_vec, 4'b0111);
        checkOutput("sat_abort_pass", bif.pass, 0);

        $display("[TB] asynchronous reset mid-settle");
        r = modelAbort(4'b0111, 7);
        startRun(4'b0111, 5);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("pre_reset_fail_count", bif.fail_count, r.fail_count);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_busy", bif.busy, 0);
        checkOutput("async_gates", {bif.gate_a, bif.gate_b}, 0);
        checkOutput("async_fail_count", bif.fail_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("post_reset_idle", bif.busy, 0);

        $display("[TB] randomized runs");
        for (int i = 0; i < 8; i++) begin
            m = 4'($urandom_range(0, 15));
            n = $urandom_range(1, 4);
            applyStimulus(m, n);
        end
        applyStimulus(4'($urandom_range(0, 15)), 255);

        $display("[TB] randomized aborts");
        for (int i = 0; i < 4; i++) begin
            m = 4'($urandom_range(1, 15));
            abortRun(m, 3, $urandom_range(1, 59));
        end

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/and_gate_bist_ctrl.md
Name: and_gate_bist_ctrl

Overview:
Built-in self-test sequencer for the top-level 2-input AND datapath (uo_out[0] = ui_in[0] & ui_in[1]).
- While busy=1, the top level muxes gate_a/gate_b onto the gate inputs in place of ui_in[1:0].
- The block walks the full truth table for a programmable number of passes and compares gate_y against the expected a&b.
- It reports a pass flag, a saturating fail count and a per-vector failure map.

Parameters:
SETTLE_CYCLES, 4, cycles each vector is held before sampling gate_y; legal range 1..255, 0 is illegal.
LOOPS_W, 8, width of the loops input.

Ports:
clk  input  1  system clock, all state updates on its rising edge
rst_n  input  1  reset; asynchronous, active-low
start  input  1  level sampled each edge; in IDLE it begins a run
abort  input  1  level sampled each edge; terminates a run
loops  input  LOOPS_W  number of full truth-table passes, latched at start; 0 = run until abort
gate_y  input  1  gate output under test
gate_a  output  1  registered gate input A
gate_b  output  1  registered gate input B
busy  output  1  high while a run is active (gate owned by controller)
done  output  1  one-cycle pulse on normal completion
pass  output  1  high after completion with zero failures; sticky until next start/abort/reset
fail_count  output  8  mismatch count, saturates at 255
fail_vec  output  4  bit i set if vector index i ever mismatched

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE. All outputs 0; vector index, settle counter, loop counter and latched loops are 0. Outputs go to 0 without a clock edge.
- Vector index idx runs 0..3 with gate_a=idx[1] and gate_b=idx[0]. Expected result = gate_a & gate_b.
- States: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE:
  - gate_a=gate_b=0, busy=0.
  - start=1 and abort=0 at an edge: latch loops; clear fail_count, fail_vec, pass, loop counter and settle counter; idx=0; busy=1; go to SETTLE.
  - start and abort both high: abort wins, stay IDLE.
- SETTLE:
  - settle counter increments each edge.
  - At the edge where counter==SETTLE_CYCLES-1: clear counter, go to SAMPLE.
  - Result: each vector is held SETTLE_CYCLES cycles in SETTLE plus 1 cycle in SAMPLE.
- SAMPLE: at the edge, compare gate_y to expected. On mismatch: fail_count+1 (hold at 255), set fail_vec[idx]. Then:
  - idx<3: idx+1, go to SETTLE.
  - idx==3 and loops!=0 and loop counter+1==latched loops: go to FINISH.
  - idx==3 otherwise: loop counter+1 (wraps at 2^LOOPS_W; irrelevant when loops=0), idx=0, go to SETTLE.
- FINISH (exactly one cycle):
  - done=1, busy=0, gate_a=gate_b=0.
  - pass = (fail_count==0), including any mismatch recorded on the final SAMPLE edge.
  - Next edge: go to IDLE.
  - start is ignored in this cycle.
- Timing: one pass lasts 4*(SETTLE_CYCLES+1) cycles. busy rises at the start edge and falls at the final SAMPLE edge; done is high in the following cycle.
- abort=1 at any edge in SETTLE/SAMPLE/FINISH:
  - Go to IDLE; busy=0, gate outputs 0, pass=0, no done pulse.
  - fail_count and fail_vec hold their values for inspection.
  - A sample coinciding with the abort edge is discarded.
- start while busy or in FINISH is ignored; loops changes after latching have no effect.
- fail_count, fail_vec and pass change only as described above.

Test Plan:
1. Good gate model, SETTLE_CYCLES=4, loops=1, start pulse -> busy high 20 cycles; (a,b) = 00,01,10,11 each held 5 cycles; done pulse 1 cycle; pass=1, fail_count=0, fail_vec=0000.
2. gate_y stuck at 1, loops=2 -> done after 40 cycles; fail_count=6, fail_vec=0111, pass=0.
3. gate_y stuck at 0, loops=3 -> fail_count=3, fail_vec=1000, pass=0; a start pulse mid-run has no effect (run still lasts 60 cycles).
4. Good gate, loops=1, abort at cycle 7 after start -> busy=0 and gate_a=gate_b=0 next edge, no done, pass=0. A new start then completes normally with pass=1.
5. gate_y stuck at 1, loops=0, run 100 passes (2000 cycles) -> fail_count=255 (saturated), busy still 1; abort -> IDLE, fail_count remains 255.
6. Assert rst_n low mid-SETTLE between clock edges -> busy, gate_a, gate_b and fail_count are 0 immediately. After release, IDLE until start.
